// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
// Upstream control stage for a 4:1 single-bit multiplexer. Steps the S1/S0
// select lines through the enabled channels in ascending order. Each channel
// is held for DWELL cycles, and MuxOut is sampled on the last edge of that
// window. The samples are assembled into a 4-bit frame, which is handed
// downstream over a valid/ready handshake. Single-shot and continuous
// scanning are supported.
//
// Optional build macro MUX_SCAN_PARITY_EN adds the FrameParity output
// (XOR of Frame), which is registered and held together with Frame.

module mux_scan_sequencer #(
   parameter int         DWELL   = 2,
   parameter logic [3:0] CH_MASK = 4'b1111
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Start,
   input  logic       Stop,
   input  logic       Cont,
   input  logic       MuxOut,
   output logic       S1,
   output logic       S0,
   output logic [3:0] Frame,
   output logic       FrameValid,
   input  logic       FrameReady,
`ifdef MUX_SCAN_PARITY_EN
   output logic       FrameParity,
`endif
   output logic       Busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_VALID  = 2'd2
   } state_t;

   // Lowest enabled channel of a mask (0 when the mask is empty).
   function automatic logic [1:0] first_channel(input logic [3:0] mask);
      logic [1:0] ch;
      ch = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i]) begin
            ch = 2'(i);
         end else begin
            ch = ch;
         end
      end
      return ch;
   endfunction

   // Next enabled channel strictly above cur (returns cur if there is none).
   function automatic logic [1:0] next_channel(input logic [3:0] mask, input logic [1:0] cur);
      logic [1:0] ch;
      ch = cur;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i] && (i > int'(cur))) begin
            ch = 2'(i);
         end else begin
            ch = ch;
         end
      end
      return ch;
   endfunction

   // True when some enabled channel lies above cur.
   function automatic logic has_next_channel(input logic [3:0] mask, input logic [1:0] cur);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (mask[i] && (i > int'(cur))) begin
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return found;
   endfunction

   // Even parity helper: XOR of the four frame bits.
   function automatic logic parity4(input logic [3:0] d);
      return ^d;
   endfunction

   localparam logic [7:0] DWELL_RELOAD = 8'(DWELL - 1);
   localparam logic [1:0] FIRST_CH     = first_channel(CH_MASK);
   localparam logic       MASK_EMPTY   = (CH_MASK == 4'b0000);

   state_t     state_r, state_s;
   logic [1:0] sel_r, sel_s;
   logic [7:0] cnt_r, cnt_s;
   logic [3:0] shadow_r, shadow_s;
   logic [3:0] frame_r, frame_s;
   logic       valid_r, valid_s;
   logic       busy_r, busy_s;
   logic       parity_r;
   logic [3:0] sample_s;

   // Shadow register with the current channel's bit replaced by the live MuxOut.
   always_comb begin
      sample_s         = shadow_r;
      sample_s[sel_r]  = MuxOut;
   end

   // Next-state and next-output logic of the scan FSM.
   always_comb begin
      state_s  = state_r;
      sel_s    = sel_r;
      cnt_s    = cnt_r;
      shadow_s = shadow_r;
      frame_s  = frame_r;
      valid_s  = valid_r;
      case (state_r)
         ST_IDLE: begin
            sel_s   = 2'b00;
            valid_s = 1'b0;
            if (Start && !Stop) begin
               if (MASK_EMPTY) begin
                  state_s = ST_VALID;
                  frame_s = 4'b0000;
                  valid_s = 1'b1;
               end else begin
                  state_s  = ST_SETTLE;
                  sel_s    = FIRST_CH;
                  cnt_s    = DWELL_RELOAD;
                  shadow_s = 4'b0000;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (Stop) begin
               state_s = ST_IDLE;
               sel_s   = 2'b00;
               cnt_s   = 8'd0;
               valid_s = 1'b0;
            end else if (cnt_r != 8'd0) begin
               cnt_s = cnt_r - 8'd1;
            end else begin
               shadow_s = sample_s;
               if (has_next_channel(CH_MASK, sel_r)) begin
                  sel_s = next_channel(CH_MASK, sel_r);
                  cnt_s = DWELL_RELOAD;
               end else begin
                  frame_s = sample_s;
                  valid_s = 1'b1;
                  state_s = ST_VALID;
               end
            end
         end
         ST_VALID: begin
            if (Stop) begin
               state_s = ST_IDLE;
               sel_s   = 2'b00;
               cnt_s   = 8'd0;
               valid_s = 1'b0;
            end else if (FrameReady) begin
               valid_s = 1'b0;
               if (Cont) begin
                  if (MASK_EMPTY) begin
                     // An empty mask completes a new (all-zero) frame immediately.
                     frame_s = 4'b0000;
                     valid_s = 1'b1;
                  end else begin
                     state_s  = ST_SETTLE;
                     sel_s    = FIRST_CH;
                     cnt_s    = DWELL_RELOAD;
                     shadow_s = 4'b0000;
                  end
               end else begin
                  state_s = ST_IDLE;
                  sel_s   = 2'b00;
               end
            end else begin
               valid_s = 1'b1;
            end
         end
         default: begin
            state_s  = ST_IDLE;
            sel_s    = 2'b00;
            cnt_s    = 8'd0;
            shadow_s = 4'b0000;
            valid_s  = 1'b0;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State and output registers; reset discards any scan or pending frame.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_r  <= ST_IDLE;
         sel_r    <= 2'b00;
         cnt_r    <= 8'd0;
         shadow_r <= 4'b0000;
         frame_r  <= 4'b0000;
         valid_r  <= 1'b0;
         busy_r   <= 1'b0;
         parity_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         sel_r    <= sel_s;
         cnt_r    <= cnt_s;
         shadow_r <= shadow_s;
         frame_r  <= frame_s;
         valid_r  <= valid_s;
         busy_r   <= busy_s;
         parity_r <= parity4(frame_s);
      end
   end

   assign S1         = sel_r[1];
   assign S0         = sel_r[0];
   assign Frame      = frame_r;
   assign FrameValid = valid_r;
   assign Busy       = busy_r;

`ifdef MUX_SCAN_PARITY_EN
   assign FrameParity = parity_r;
`else
   // Parity register has no consumer in this build; it is optimised away.
   logic unused_parity_s;
   assign unused_parity_s = parity_r;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Testbench for mux_scan_sequencer: four instances with different DWELL and
// CH_MASK settings share the control inputs. Each instance drives its own
// behavioural 4:1 mux, whose inputs come from a common data vector. A
// transaction-level reference model derives every expected output.

module tb_mux_scan_sequencer;

   localparam int         NDUT          = 4;
   localparam int         DW [NDUT]     = '{2, 3, 1, 1};
   localparam logic [3:0] MK [NDUT]     = '{4'b1111, 4'b1010, 4'b0100, 4'b0000};

   logic       Clk = 1'b0;
   logic       Rst_n;
   logic       start, stop, cont, ready;
   logic [3:0] data;

   logic       s1_o    [NDUT];
   logic       s0_o    [NDUT];
   logic       fv_o    [NDUT];
   logic       busy_o  [NDUT];
   logic       mux_in  [NDUT];
   logic [3:0] frame_o [NDUT];
   logic       parity_o [NDUT];

   int checks   = 0;
   int failures = 0;

   // reference model state
   bit         m_scan   [NDUT];
   bit         m_valid  [NDUT];
   int         m_t      [NDUT];
   logic [3:0] m_shadow [NDUT];
   logic [3:0] m_frame  [NDUT];
   int         ch_tab   [NDUT][4];
   int         n_ch     [NDUT];

   always #5 Clk = ~Clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      assign mux_in[g] = data[{s1_o[g], s0_o[g]}];
`ifndef MUX_SCAN_PARITY_EN
      assign parity_o[g] = ^frame_o[g];
`endif
      mux_scan_sequencer #(.DWELL(DW[g]), .CH_MASK(MK[g])) u_dut (
         .Clk        (Clk),
         .Rst_n      (Rst_n),
         .Start      (start),
         .Stop       (stop),
         .Cont       (cont),
         .MuxOut     (mux_in[g]),
         .S1         (s1_o[g]),
         .S0         (s0_o[g]),
         .Frame      (frame_o[g]),
         .FrameValid (fv_o[g]),
         .FrameReady (ready),
`ifdef MUX_SCAN_PARITY_EN
         .FrameParity(parity_o[g]),
`endif
         .Busy       (busy_o[g])
      );
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NDUT; k++) begin
         m_scan[k]   = 1'b0;
         m_valid[k]  = 1'b0;
         m_t[k]      = 0;
         m_shadow[k] = 4'b0000;
         m_frame[k]  = 4'b0000;
      end
   endtask

   task automatic begin_scan(input int k);
      if (n_ch[k] == 0) begin
         m_frame[k] = 4'b0000;
         m_valid[k] = 1'b1;
      end else begin
         m_scan[k]   = 1'b1;
         m_t[k]      = 0;
         m_shadow[k] = 4'b0000;
      end
   endtask

   // One clock edge of the reference: m_t counts cycles elapsed in the scan.
   task automatic model_step(input int k);
      if (m_valid[k]) begin
         if (stop) begin
            m_valid[k] = 1'b0;
         end else if (ready) begin
            m_valid[k] = 1'b0;
            if (cont) begin_scan(k);
         end
      end else if (m_scan[k]) begin
         if (stop) begin
            m_scan[k] = 1'b0;
         end else begin
            int ch;
            ch = ch_tab[k][m_t[k] / DW[k]];
            if ((m_t[k] % DW[k]) == DW[k] - 1) m_shadow[k][ch] = data[ch];
            m_t[k]++;
            if (m_t[k] == n_ch[k] * DW[k]) begin
               m_frame[k] = m_shadow[k];
               m_valid[k] = 1'b1;
               m_scan[k]  = 1'b0;
            end
         end
      end else if (start && !stop) begin
         begin_scan(k);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < NDUT; k++) begin
         logic [1:0] exp_sel;
         check_val($sformatf("valid%0d", k), fv_o[k], m_valid[k]);
         check_val($sformatf("busy%0d", k), busy_o[k], m_scan[k] | m_valid[k]);
         check_val($sformatf("frame%0d", k), frame_o[k], m_frame[k]);
         check_val($sformatf("parity%0d", k), parity_o[k], ^m_frame[k]);
         if (!m_valid[k]) begin
            exp_sel = m_scan[k] ? 2'(ch_tab[k][m_t[k] / DW[k]]) : 2'b00;
            check_val($sformatf("sel%0d", k), {s1_o[k], s0_o[k]}, exp_sel);
         end
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      for (int k = 0; k < NDUT; k++) model_step(k);
      #1;
      check_all();
   endtask

   initial begin
      for (int k = 0; k < NDUT; k++) begin
         n_ch[k] = 0;
         for (int c = 0; c < 4; c++) begin
            ch_tab[k][c] = 0;
            if (MK[k][c]) begin
               ch_tab[k][n_ch[k]] = c;
               n_ch[k]++;
            end
         end
      end
      Rst_n = 1'b0;
      start = 1'b0; stop = 1'b0; cont = 1'b0; ready = 1'b0;
      data  = 4'b0000;
      model_reset();
      #2;
      check_all();
      #6 Rst_n = 1'b1;

      // single shot with default settings, then backpressure
      data  = 4'b1010;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      check_val("ss_early_valid", fv_o[0], 1'b0);
      tick();
      check_val("ss_valid", fv_o[0], 1'b1);
      check_val("ss_frame", frame_o[0], 4'b1010);
      check_val("mask1010_frame", frame_o[1], 4'b1010);
      repeat (5) tick();
      check_val("bp_frame", frame_o[0], 4'b1010);
      check_val("bp_valid", fv_o[0], 1'b1);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check_val("hs_busy", busy_o[0], 1'b0);
      check_val("hs_valid", fv_o[0], 1'b0);

      // stop during the third cycle of a scan
      data  = 4'b0101;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_val("stop_busy", busy_o[0], 1'b0);
      check_val("stop_frame", frame_o[0], 4'b1010);
      check_val("stop_valid", fv_o[0], 1'b0);

      // start and stop together in idle
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check_val("startstop_busy", busy_o[0], 1'b0);
      tick();

      // asynchronous reset while channel 2 is selected
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check_val("pre_rst_sel", {s1_o[0], s0_o[0]}, 2'b10);
      #3 Rst_n = 1'b0;
      #1;
      check_val("rst_sel", {s1_o[0], s0_o[0]}, 2'b00);
      check_val("rst_valid", fv_o[0], 1'b0);
      check_val("rst_busy", busy_o[0], 1'b0);
      model_reset();
      check_all();
      #1 Rst_n = 1'b1;

      // continuous mode, back-to-back frames
      cont  = 1'b1; ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 32; i++) begin
         data = 4'($urandom);
         tick();
      end
      cont = 1'b0;
      repeat (10) tick();

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         start = ($urandom_range(0, 3) == 0);
         stop  = ($urandom_range(0, 24) == 0);
         cont  = 1'($urandom_range(0, 1));
         ready = ($urandom_range(0, 2) != 0);
         data  = 4'($urandom);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
